distance_offset_apply: RTL and testbench



---
 rtl/distance_offset_apply_pkg.sv | 14 +
 rtl/distance_offset_apply_if.sv | 29 ++
 rtl/distance_offset_apply_sat_sub.sv | 26 ++
 rtl/distance_offset_apply.sv | 115 +++++++++++
 tb/tb_distance_offset_apply.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/distance_offset_apply_pkg.sv
// Shared ranging definitions: default widths, the no-echo code and the
// sequencer state encoding used by the offset-apply stage.
package ranging_pkg;

  localparam int DW_DEFAULT = 16;
  localparam int IW_DEFAULT = 12;
  localparam logic [15:0] NO_ECHO_CODE = 16'hFFFF;

  typedef enum logic {
    st_sync = 1'b0,
    st_run  = 1'b1
  } state_e;

endpackage

// File: rtl/distance_offset_apply_if.sv
// Measurement-in / corrected-point-out bundle of the offset-apply stage.
// The master side feeds the stream; the slave side is the stage itself.
interface distance_offset_apply_if
  import ranging_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int IW = IW_DEFAULT
);
  logic          zero_flag;
  logic [DW-1:0] zero_offset;
  logic          meas_valid;
  logic [DW-1:0] meas_data;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [IW-1:0] out_index;
  logic          out_sof;
  logic          frame_err;
  logic [IW-1:0] last_count;

  modport master (
    output zero_flag, zero_offset, meas_valid, meas_data,
    input  out_valid, out_data, out_index, out_sof, frame_err, last_count
  );

  modport slave (
    input  zero_flag, zero_offset, meas_valid, meas_data,
    output out_valid, out_data, out_index, out_sof, frame_err, last_count
  );
endinterface

// File: rtl/distance_offset_apply_sat_sub.sv
// Offset subtraction with clamping to [0, max]; the bypass code passes
// through untouched so "no return" markers survive correction.
module sat_sub #(
  parameter int DW = 16
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] max,
  input  logic [DW-1:0] bypass_code,
  output logic [DW-1:0] y
);
  logic [DW:0] diff;

  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    y = diff[DW-1:0];
    if (a == bypass_code) begin
      y = bypass_code;
    end else if (diff[DW]) begin
      y = '0;
    end else if (diff > {1'b0, max}) begin
      y = max;
    end
  end
endmodule

// File: rtl/distance_offset_apply.sv
// Applies the per-revolution zero offset to the raw distance stream, tags
// each point with its angular index and flags short/long revolutions.
module distance_offset_apply
  import ranging_pkg::*;
#(
  parameter int            DW             = DW_DEFAULT,
  parameter int            IW             = IW_DEFAULT,
  parameter int            POINTS_PER_REV = 1800,
  parameter int            MAX_RANGE      = 30000,
  parameter logic [DW-1:0] NO_ECHO        = NO_ECHO_CODE
) (
  input  logic                    clk,
  input  logic                    rst,
  distance_offset_apply_if.slave  bus
);
  localparam logic [IW-1:0] PPR     = IW'(POINTS_PER_REV);
  localparam logic [DW-1:0] MAX_VAL = DW'(MAX_RANGE);

  state_e        state_q;
  logic [IW-1:0] idx_q;
  logic [IW-1:0] last_count_q;
  logic [DW-1:0] off_sh_q;
  logic          long_q;
  logic          frame_err_q;

  logic          s1_valid_q;
  logic          s1_sof_q;
  logic [DW-1:0] s1_data_q;
  logic [DW-1:0] s1_off_q;
  logic [IW-1:0] s1_index_q;

  logic          out_valid_q;
  logic          out_sof_q;
  logic [DW-1:0] out_data_q;
  logic [IW-1:0] out_index_q;

  logic          full;
  logic          accept;
  logic          drop;
  logic [IW-1:0] idx_sel;
  logic [DW-1:0] sat_y;

  assign full    = (idx_q == PPR);
  // A zero mark arriving with a sample opens the new revolution for it.
  assign accept  = bus.meas_valid && (bus.zero_flag || (state_q == st_run && !full));
  assign drop    = bus.meas_valid && !bus.zero_flag && (state_q == st_run) && full;
  assign idx_sel = bus.zero_flag ? '0 : idx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= st_sync;
      idx_q        <= '0;
      last_count_q <= '0;
      off_sh_q     <= '0;
      long_q       <= 1'b0;
      frame_err_q  <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_sof_q     <= 1'b0;
      s1_data_q    <= '0;
      s1_off_q     <= '0;
      s1_index_q   <= '0;
      out_valid_q  <= 1'b0;
      out_sof_q    <= 1'b0;
      out_data_q   <= '0;
      out_index_q  <= '0;
    end else begin
      frame_err_q <= 1'b0;
      if (bus.zero_flag) begin
        off_sh_q <= bus.zero_offset;
        state_q  <= st_run;
        long_q   <= 1'b0;
        idx_q    <= accept ? IW'(1) : '0;
        if (state_q == st_run) begin
          last_count_q <= idx_q;
          frame_err_q  <= !full;
        end
      end else if (accept) begin
        idx_q <= idx_q + IW'(1);
      end else if (drop && !long_q) begin
        long_q      <= 1'b1;
        frame_err_q <= 1'b1;
      end

      s1_valid_q <= accept;
      if (accept) begin
        s1_data_q  <= bus.meas_data;
        s1_index_q <= idx_sel;
        s1_sof_q   <= (idx_sel == '0);
        s1_off_q   <= bus.zero_flag ? bus.zero_offset : off_sh_q;
      end

      out_valid_q <= s1_valid_q;
      out_sof_q   <= s1_valid_q && s1_sof_q;
      if (s1_valid_q) begin
        out_data_q  <= sat_y;
        out_index_q <= s1_index_q;
      end
    end
  end

  sat_sub #(.DW(DW)) u_sat_sub (
    .a           (s1_data_q),
    .b           (s1_off_q),
    .max         (MAX_VAL),
    .bypass_code (NO_ECHO),
    .y           (sat_y)
  );

  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_index  = out_index_q;
  assign bus.out_sof    = out_sof_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.last_count = last_count_q;
endmodule

// File: tb/tb_distance_offset_apply.sv
// Scoreboard bench for distance_offset_apply with an 8-point revolution.
module tb_distance_offset_apply;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   err_cnt = 0;
  int   last_err_cyc = -1;

  typedef struct {
    logic [15:0] d;
    logic [11:0] i;
    logic        s;
    int          c;
  } exp_t;

  exp_t q[$];

  distance_offset_apply_if #(.DW(16), .IW(12)) bus ();

  distance_offset_apply #(
    .DW(16), .IW(12), .POINTS_PER_REV(8), .MAX_RANGE(30000), .NO_ECHO(16'hFFFF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Output monitor: every out_valid must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (bus.frame_err) begin
      err_cnt++;
      last_err_cyc = cyc;
    end
    if (bus.out_valid) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_out data=%0d index=%0d cyc=%0d", bus.out_data, bus.out_index, cyc);
      end else begin
        e = q.pop_front();
        if (bus.out_data !== e.d || bus.out_index !== e.i || bus.out_sof !== e.s || cyc != e.c) begin
          failures++;
          $display("FAIL out_point got d=%0d i=%0d sof=%0b cyc=%0d exp d=%0d i=%0d sof=%0b cyc=%0d",
                   bus.out_data, bus.out_index, bus.out_sof, cyc, e.d, e.i, e.s, e.c);
        end
      end
    end
  end

  task automatic push_exp(input logic [15:0] d, input logic [11:0] i, input logic s);
    exp_t e;
    e.d = d; e.i = i; e.s = s; e.c = cyc + 2;
    q.push_back(e);
  endtask

  task automatic drive(input logic zf, input logic mv, input logic [15:0] md);
    bus.zero_flag  = zf;
    bus.meas_valid = mv;
    bus.meas_data  = md;
    @(negedge clk);
    bus.zero_flag  = 1'b0;
    bus.meas_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 16'd0 || bus.out_index !== 12'd0 ||
        bus.out_sof !== 1'b0 || bus.frame_err !== 1'b0 || bus.last_count !== 12'd0) begin
      failures++;
      $display("FAIL reset_state got v=%0b d=%0d i=%0d sof=%0b err=%0b lc=%0d exp all 0",
               bus.out_valid, bus.out_data, bus.out_index, bus.out_sof, bus.frame_err, bus.last_count);
    end
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_pre_sync();
    for (int k = 0; k < 5; k++) drive(1'b0, 1'b1, 16'(2000 + k));
    idle(3);
    checks++;
    if (err_cnt != 0) begin
      failures++;
      $display("FAIL pre_sync_err got %0d exp 0", err_cnt);
    end
  endtask

  task automatic test_basic();
    bus.zero_offset = 16'd120;
    drive(1'b1, 1'b0, 16'd0);
    push_exp(16'd1000, 12'd0, 1'b1);
    drive(1'b0, 1'b1, 16'd1120);
    push_exp(16'd4880, 12'd1, 1'b0);
    drive(1'b0, 1'b1, 16'd5000);
    idle(3);
    checks++;
    if (err_cnt != 0 || bus.last_count !== 12'd0) begin
      failures++;
      $display("FAIL first_zero got err=%0d lc=%0d exp err=0 lc=0", err_cnt, bus.last_count);
    end
  endtask

  task automatic test_clamp_bypass();
    push_exp(16'd0, 12'd2, 1'b0);
    drive(1'b0, 1'b1, 16'd100);
    push_exp(16'd30000, 12'd3, 1'b0);
    drive(1'b0, 1'b1, 16'd31000);
    push_exp(16'hFFFF, 12'd4, 1'b0);
    drive(1'b0, 1'b1, 16'hFFFF);
    push_exp(16'd30000, 12'd5, 1'b0);
    drive(1'b0, 1'b1, 16'd30120);
    idle(3);
  endtask

  task automatic test_short_frame();
    int e0;
    int c0;
    e0 = err_cnt;
    c0 = cyc;
    drive(1'b1, 1'b0, 16'd0);
    idle(2);
    checks++;
    if (err_cnt != e0 + 1 || last_err_cyc != c0 + 1) begin
      failures++;
      $display("FAIL short_err got cnt=%0d cyc=%0d exp cnt=%0d cyc=%0d", err_cnt, last_err_cyc, e0 + 1, c0 + 1);
    end
    checks++;
    if (bus.last_count !== 12'd6) begin
      failures++;
      $display("FAIL short_last_count got %0d exp 6", bus.last_count);
    end
    for (int k = 0; k < 8; k++) begin
      push_exp(16'(k * 10), 12'(k), (k == 0));
      drive(1'b0, 1'b1, 16'(120 + k * 10));
    end
    idle(3);
    e0 = err_cnt;
    drive(1'b1, 1'b0, 16'd0);
    idle(2);
    checks++;
    if (err_cnt != e0 || bus.last_count !== 12'd8) begin
      failures++;
      $display("FAIL exact_frame got err=%0d lc=%0d exp err=%0d lc=8", err_cnt, bus.last_count, e0);
    end
  endtask

  task automatic test_long_frame();
    int e0;
    int c9;
    e0 = err_cnt;
    c9 = 0;
    for (int k = 0; k < 10; k++) begin
      if (k < 8) push_exp(16'(500 + k), 12'(k), (k == 0));
      if (k == 8) c9 = cyc;
      drive(1'b0, 1'b1, 16'(620 + k));
    end
    idle(3);
    checks++;
    if (err_cnt != e0 + 1 || last_err_cyc != c9 + 1) begin
      failures++;
      $display("FAIL long_err got cnt=%0d cyc=%0d exp cnt=%0d cyc=%0d", err_cnt, last_err_cyc, e0 + 1, c9 + 1);
    end
    e0 = err_cnt;
    drive(1'b1, 1'b0, 16'd0);
    idle(2);
    checks++;
    if (err_cnt != e0 || bus.last_count !== 12'd8) begin
      failures++;
      $display("FAIL long_close got err=%0d lc=%0d exp err=%0d lc=8", err_cnt, bus.last_count, e0);
    end
  endtask

  task automatic test_shadow_collision();
    int e0;
    push_exp(16'd880, 12'd0, 1'b1);
    drive(1'b0, 1'b1, 16'd1000);
    push_exp(16'd1880, 12'd1, 1'b0);
    drive(1'b0, 1'b1, 16'd2000);
    bus.zero_offset = 16'd200;
    idle(2);
    push_exp(16'd2880, 12'd2, 1'b0);
    drive(1'b0, 1'b1, 16'd3000);
    push_exp(16'd80, 12'd3, 1'b0);
    drive(1'b0, 1'b1, 16'd200);
    idle(1);
    e0 = err_cnt;
    push_exp(16'd1000, 12'd0, 1'b1);
    drive(1'b1, 1'b1, 16'd1200);
    push_exp(16'd1100, 12'd1, 1'b0);
    drive(1'b0, 1'b1, 16'd1300);
    idle(3);
    checks++;
    if (err_cnt != e0 + 1 || bus.last_count !== 12'd4) begin
      failures++;
      $display("FAIL collision_frame got err=%0d lc=%0d exp err=%0d lc=4", err_cnt, bus.last_count, e0 + 1);
    end
  endtask

  task automatic test_reset_inflight();
    int e0;
    drive(1'b0, 1'b1, 16'd5000);
    rst = 1'b1;
    idle(1);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL inflight_valid got %0b exp 0", bus.out_valid);
    end
    idle(1);
    rst = 1'b0;
    idle(1);
    checks++;
    if (bus.last_count !== 12'd0) begin
      failures++;
      $display("FAIL post_reset_lc got %0d exp 0", bus.last_count);
    end
    drive(1'b0, 1'b1, 16'd4000);
    drive(1'b0, 1'b1, 16'd4100);
    idle(3);
    e0 = err_cnt;
    push_exp(16'd1000, 12'd0, 1'b1);
    drive(1'b1, 1'b1, 16'd1200);
    push_exp(16'd2000, 12'd1, 1'b0);
    drive(1'b0, 1'b1, 16'd2200);
    idle(4);
    checks++;
    if (err_cnt != e0) begin
      failures++;
      $display("FAIL resync_err got %0d exp %0d", err_cnt, e0);
    end
  endtask

  initial begin
    bus.zero_flag   = 1'b0;
    bus.zero_offset = 16'd0;
    bus.meas_valid  = 1'b0;
    bus.meas_data   = 16'd0;
    @(negedge clk);
    test_reset();
    test_pre_sync();
    test_basic();
    test_clamp_bypass();
    test_short_frame();
    test_long_frame();
    test_shadow_collision();
    test_reset_inflight();
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got %0d pending exp 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
